// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-cache bus between the fetch stage and the I-cache
//
// Signals:
//   imemREN   fetch -> cache  instruction read enable
//   imemaddr  fetch -> cache  fetch address (the PC register)
//   ihit      cache -> fetch  imemload is valid this cycle
//   imemload  cache -> fetch  instruction word
interface fetch_stage_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;

    modport master (
        output imemREN,
        output imemaddr,
        input  ihit,
        input  imemload
    );

    modport slave (
        input  imemREN,
        input  imemaddr,
        output ihit,
        output imemload
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC, next-PC select, IF/ID register
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   imem (master)             I-cache bus: imemREN/imemaddr out, ihit/imemload in
//   pc_wen, if_id_wen,
//   if_id_flush               hazard-unit strobes
//   pc_src, *_target          redirect select and candidate targets
//   halt                      halt retired in WB; stops fetch until reset
//   if_id_*                   IF/ID pipeline register outputs
//   halted, fetch_count       status
module fetch_stage #(
    parameter logic [31:0] PCSTART = 32'h0000_0000
) (
    input  logic                 CLK,
    input  logic                 RST,
    fetch_stage_if.master        imem,
    input  logic                 pc_wen,
    input  logic                 if_id_wen,
    input  logic                 if_id_flush,
    input  logic [1:0]           pc_src,
    input  logic [31:0]          branch_target,
    input  logic [31:0]          jump_target,
    input  logic [31:0]          jr_target,
    input  logic                 halt,
    output logic [31:0]          if_id_instr,
    output logic [31:0]          if_id_pc,
    output logic [31:0]          if_id_npc,
    output logic                 if_id_valid,
    output logic                 halted,
    output logic [31:0]          fetch_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pending_valid_q, pending_valid_d;
    logic [31:0] pending_target_q, pending_target_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] inpc_q, inpc_d;
    logic        ivalid_q, ivalid_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    logic        redirect;
    logic [31:0] next_pc;

    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = (pc_src != 2'b00);

    always_comb begin
        redirect_target = branch_target;
        case (pc_src)
            2'b10:   redirect_target = jump_target;
            2'b11:   redirect_target = jr_target;
            default: redirect_target = branch_target;
        endcase
    end

    // A fresh redirect outranks a pending one; pending outranks sequential.
    always_comb begin
        if (redirect)             next_pc = redirect_target;
        else if (pending_valid_q) next_pc = pending_target_q;
        else                      next_pc = pc_plus4;
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        pending_valid_d  = pending_valid_q;
        pending_target_d = pending_target_q;
        instr_d          = instr_q;
        ipc_d            = ipc_q;
        inpc_d           = inpc_q;
        ivalid_d         = ivalid_q;
        count_d          = count_q;

        if (state_q == RUN) begin
            if (halt) begin
                // The halting edge must not advance the PC even if pc_wen is set.
                state_d = HALTED;
            end else if (pc_wen) begin
                pc_d            = next_pc;
                pending_valid_d = 1'b0;
            end else if (redirect) begin
                pending_valid_d  = 1'b1;
                pending_target_d = redirect_target;
            end

            // A stall holds the slot even when a flush is requested.
            if (if_id_wen) begin
                if (!if_id_flush && imem.ihit) begin
                    instr_d  = imem.imemload;
                    ipc_d    = pc_q;
                    inpc_d   = pc_plus4;
                    ivalid_d = 1'b1;
                    count_d  = count_q + 32'd1;
                end else begin
                    instr_d  = 32'd0;
                    ipc_d    = 32'd0;
                    inpc_d   = 32'd0;
                    ivalid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q          <= RUN;
            pc_q             <= PCSTART;
            pending_valid_q  <= 1'b0;
            pending_target_q <= 32'd0;
            instr_q          <= 32'd0;
            ipc_q            <= 32'd0;
            inpc_q           <= 32'd0;
            ivalid_q         <= 1'b0;
            count_q          <= 32'd0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            pending_valid_q  <= pending_valid_d;
            pending_target_q <= pending_target_d;
            instr_q          <= instr_d;
            ipc_q            <= ipc_d;
            inpc_q           <= inpc_d;
            ivalid_q         <= ivalid_d;
            count_q          <= count_d;
        end
    end

    assign imem.imemaddr = pc_q;
    assign imem.imemREN  = (state_q == RUN);
    assign halted        = (state_q == HALTED);
    assign if_id_instr   = instr_q;
    assign if_id_pc      = ipc_q;
    assign if_id_npc     = inpc_q;
    assign if_id_valid   = ivalid_q;
    assign fetch_count   = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed-vector bench for fetch_stage
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        pc_wen, if_id_wen, if_id_flush, halt;
    logic [1:0]  pc_src;
    logic [31:0] branch_target, jump_target, jr_target;
    logic [31:0] if_id_instr, if_id_pc, if_id_npc, fetch_count;
    logic        if_id_valid, halted;

    int n_vec = 0;
    int n_err = 0;

    fetch_stage_if imem ();

    fetch_stage #(.PCSTART(32'h0000_0040)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .imem          (imem),
        .pc_wen        (pc_wen),
        .if_id_wen     (if_id_wen),
        .if_id_flush   (if_id_flush),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .jr_target     (jr_target),
        .halt          (halt),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_npc     (if_id_npc),
        .if_id_valid   (if_id_valid),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; pc_wen = 1'b1; if_id_wen = 1'b1; if_id_flush = 1'b0; halt = 1'b0;
        pc_src = 2'b00; branch_target = 32'd0; jump_target = 32'd0; jr_target = 32'd0;
        imem.ihit = 1'b1; imem.imemload = 32'h1111_1111;
        step();
        check("rst_addr",   imem.imemaddr, 32'h40);
        check("rst_ren",    {31'd0, imem.imemREN}, 32'd1);
        check("rst_valid",  {31'd0, if_id_valid}, 32'd0);
        check("rst_instr",  if_id_instr, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_count",  fetch_count, 32'd0);

        // Sequential fetch
        RST = 1'b0;
        step();
        check("seq1_addr",  imem.imemaddr, 32'h44);
        check("seq1_pc",    if_id_pc, 32'h40);
        check("seq1_npc",   if_id_npc, 32'h44);
        check("seq1_instr", if_id_instr, 32'h1111_1111);
        imem.imemload = 32'h2222_2222;
        step();
        check("seq2_addr",  imem.imemaddr, 32'h48);
        check("seq2_pc",    if_id_pc, 32'h44);
        step();
        check("seq3_addr",  imem.imemaddr, 32'h4C);
        check("seq3_count", fetch_count, 32'd3);

        // Stalled branch becomes pending
        pc_wen = 1'b0; if_id_wen = 1'b0; pc_src = 2'b01; branch_target = 32'h200;
        step();
        check("stall1_addr", imem.imemaddr, 32'h4C);
        pc_src = 2'b00;
        step();
        step();
        check("stall3_addr",    imem.imemaddr, 32'h4C);
        check("stall_pend",     {31'd0, dut.pending_valid_q}, 32'd1);
        check("stall_count",    fetch_count, 32'd3);
        pc_wen = 1'b1;
        step();
        check("br_taken_addr",  imem.imemaddr, 32'h200);
        check("br_pend_clear",  {31'd0, dut.pending_valid_q}, 32'd0);
        step();
        check("br_after_addr",  imem.imemaddr, 32'h204);

        // Pending jump overridden by simultaneous jr
        pc_wen = 1'b0; pc_src = 2'b10; jump_target = 32'h300;
        step();
        check("jpend_addr", imem.imemaddr, 32'h204);
        pc_src = 2'b11; jr_target = 32'h500; pc_wen = 1'b1;
        step();
        check("jr_win_addr", imem.imemaddr, 32'h500);
        pc_src = 2'b00;
        step();
        check("jr_after_addr", imem.imemaddr, 32'h504);

        // Stall beats flush
        if_id_wen = 1'b1; imem.imemload = 32'h8C22_0004;
        step();
        check("ld_instr", if_id_instr, 32'h8C22_0004);
        check("ld_pc",    if_id_pc, 32'h504);
        check("ld_count", fetch_count, 32'd4);
        if_id_wen = 1'b0; if_id_flush = 1'b1;
        step();
        check("sf_instr", if_id_instr, 32'h8C22_0004);
        check("sf_valid", {31'd0, if_id_valid}, 32'd1);
        if_id_wen = 1'b1;
        step();
        check("fl_instr", if_id_instr, 32'd0);
        check("fl_valid", {31'd0, if_id_valid}, 32'd0);
        check("fl_count", fetch_count, 32'd4);
        check("fl_addr",  imem.imemaddr, 32'h510);

        // I-cache miss
        if_id_flush = 1'b0; imem.ihit = 1'b0; pc_wen = 1'b0;
        step();
        check("miss1_valid", {31'd0, if_id_valid}, 32'd0);
        step();
        check("miss2_valid", {31'd0, if_id_valid}, 32'd0);
        check("miss_addr",   imem.imemaddr, 32'h510);
        check("miss_count",  fetch_count, 32'd4);

        // PC+4 wrap
        imem.ihit = 1'b1; imem.imemload = 32'hAAAA_0000; pc_wen = 1'b1;
        pc_src = 2'b11; jr_target = 32'hFFFF_FFFC;
        step();
        check("wrap_addr0", imem.imemaddr, 32'hFFFF_FFFC);
        pc_src = 2'b00;
        step();
        check("wrap_addr1", imem.imemaddr, 32'h0);
        check("wrap_ipc",   if_id_pc, 32'hFFFF_FFFC);
        check("wrap_npc",   if_id_npc, 32'h0);
        check("wrap_count", fetch_count, 32'd6);

        // Halt at 0x60
        pc_src = 2'b10; jump_target = 32'h60;
        step();
        check("h_pre_addr", imem.imemaddr, 32'h60);
        pc_src = 2'b00; halt = 1'b1; imem.ihit = 1'b0;
        step();
        check("h_halted", {31'd0, halted}, 32'd1);
        check("h_ren",    {31'd0, imem.imemREN}, 32'd0);
        check("h_addr",   imem.imemaddr, 32'h60);
        halt = 1'b0; imem.ihit = 1'b1; pc_src = 2'b01; branch_target = 32'h900;
        step();
        step();
        step();
        check("h_hold_addr",  imem.imemaddr, 32'h60);
        check("h_hold_count", fetch_count, 32'd7);
        check("h_hold_flag",  {31'd0, halted}, 32'd1);
        pc_src = 2'b00;
        RST = 1'b1;
        step();
        check("hr_addr",   imem.imemaddr, 32'h40);
        check("hr_halted", {31'd0, halted}, 32'd0);
        check("hr_ren",    {31'd0, imem.imemREN}, 32'd1);
        check("hr_count",  fetch_count, 32'd0);
        RST = 1'b0;
        step();
        check("hr_run_addr", imem.imemaddr, 32'h44);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
